// File: rtl/rot_pkg.sv
// Shared types and constants for the rotate arbiter: FSM states, datapath widths,
// and helpers for the rotate step size and the two-requester round-robin pick.
package rot_pkg;

    localparam int unsigned DATA_W   = 4;
    localparam int unsigned AMT_W    = 4;
    localparam int unsigned STEP_MAX = 3;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } rot_state_e;

    // Largest rotate step the single-cycle rotator can apply for the remaining amount.
    function automatic logic [SEL_W-1:0] step_of(input logic [AMT_W-1:0] rem);
        logic [SEL_W-1:0] step;
        if (rem > AMT_W'(STEP_MAX)) begin
            step = SEL_W'(STEP_MAX);
        end else begin
            step = rem[SEL_W-1:0];
        end
        return step;
    endfunction

    // One-hot grant; ptr names the requester preferred on a tie.
    function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic ptr);
        logic [1:0] grant;
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/bshifter4b.sv
// 4-bit combinational right-rotator; i_sel selects a rotate of 0..3 positions.
module bshifter4b (
    input  logic [3:0] i_data,
    input  logic [1:0] i_sel,
    output logic [3:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_sel)
            2'd0:    o_data = i_data;
            2'd1:    o_data = {i_data[0],   i_data[3:1]};
            2'd2:    o_data = {i_data[1:0], i_data[3:2]};
            2'd3:    o_data = {i_data[2:0], i_data[3]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/rot_arbiter.sv
// Two-requester round-robin arbiter feeding a multi-cycle right-rotate engine.
// Optional per-requester grant counters are built when ROT_ARBITER_STATS_EN is defined.
module rot_arbiter
    import rot_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [AMT_W-1:0]  req_amt0,
    input  logic [AMT_W-1:0]  req_amt1,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_id,
`ifdef ROT_ARBITER_STATS_EN
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
`endif
    output logic              busy
);

    rot_state_e        r_state;
    rot_state_e        w_state_next;
    logic              r_ptr;
    logic [DATA_W-1:0] r_data;
    logic              r_id;
    logic [AMT_W-1:0]  r_rem;

    logic [1:0]        w_grant;
    logic              w_accept;
    logic              w_gid;
    logic [DATA_W-1:0] w_sel_data;
    logic [AMT_W-1:0]  w_sel_amt;
    logic [SEL_W-1:0]  w_step;
    logic [AMT_W-1:0]  w_rem_next;
    logic [DATA_W-1:0] w_rot_data;

    // Grants are only offered while idle so a pending request is held off, not dropped.
    assign w_grant    = (r_state == IDLE) ? rr_pick(req_valid, r_ptr) : 2'b00;
    assign w_accept   = |w_grant;
    assign w_gid      = w_grant[1];
    assign w_sel_data = w_gid ? req_data1 : req_data0;
    assign w_sel_amt  = w_gid ? req_amt1 : req_amt0;

    assign w_step     = step_of(r_rem);
    assign w_rem_next = r_rem - AMT_W'(w_step);

    bshifter4b u_rot (
        .i_data (r_data),
        .i_sel  (w_step),
        .o_data (w_rot_data)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_sel_amt == '0) ? DONE : ROT;
                end
            end
            ROT: begin
                if (w_rem_next == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
            r_id   <= 1'b0;
            r_rem  <= '0;
            r_ptr  <= 1'b0;
        end else if (w_accept) begin
            r_data <= w_sel_data;
            r_id   <= w_gid;
            r_rem  <= w_sel_amt;
            r_ptr  <= ~w_gid;
        end else if (r_state == ROT) begin
            r_data <= w_rot_data;
            r_rem  <= w_rem_next;
        end
    end

    assign req_ready = w_grant;
    assign res_valid = (r_state == DONE);
    assign res_data  = r_data;
    assign res_id    = r_id;
    assign busy      = (r_state != IDLE);

`ifdef ROT_ARBITER_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_accept) begin
            if (w_gid) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end else begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_rot_arbiter.sv
// Self-checking bench for rot_arbiter: directed vector table, corner sequences and random
// traffic against a transaction-level model. Honours ROT_ARBITER_STATS_EN when defined.
module tb_rot_arbiter;

    localparam int unsigned CNT_W = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_data0;
    logic [3:0] req_data1;
    logic [3:0] req_amt0;
    logic [3:0] req_amt1;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_id;
    logic       busy;
`ifdef ROT_ARBITER_STATS_EN
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;
`endif

    always #5 clk = ~clk;

    rot_arbiter #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_amt0  (req_amt0),
        .req_amt1  (req_amt1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
`ifdef ROT_ARBITER_STATS_EN
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic       id;
        logic [3:0] data;
        logic [3:0] amt;
        logic [3:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t vecs[10];
    int   n_checks = 0;
    int   n_err    = 0;
    logic accepted;

    // Transaction-level model: an operation is either absent or waiting out its latency.
    bit         m_busy = 1'b0;
    int         m_wait = 0;
    logic [3:0] m_res  = 4'h0;
    logic       m_id   = 1'b0;
    int         m_pref = 0;
    int         m_cnt[2] = '{0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] rotr(input logic [3:0] d, input logic [3:0] amt);
        logic [7:0] t;
        t = {d, d} >> (amt % 4);
        return t[3:0];
    endfunction

    function automatic logic [1:0] pick(input logic [1:0] v, input int pref);
        int w;
        if (v == 2'b00) return 2'b00;
        if (v == 2'b11) w = pref;
        else w = v[1] ? 1 : 0;
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    // Compare outputs just after the falling edge, advance the model, then cross one cycle.
    task automatic tick();
        logic [1:0] er;
        logic       ev;
        int         w;
        logic [3:0] amt;
        #1;
        er = m_busy ? 2'b00 : pick(req_valid, m_pref);
        ev = m_busy && (m_wait == 0);
        chk("req_ready", req_ready, er);
        chk("res_valid", res_valid, ev);
        chk("busy", busy, m_busy);
        if (ev) begin
            chk("res_data", res_data, m_res);
            chk("res_id", res_id, m_id);
        end
`ifdef ROT_ARBITER_STATS_EN
        chk("grant_cnt0", grant_cnt0, m_cnt[0] % (1 << CNT_W));
        chk("grant_cnt1", grant_cnt1, m_cnt[1] % (1 << CNT_W));
`endif
        accepted = |(req_valid & req_ready);
        if (!rst_n) begin
            m_busy = 1'b0;
            m_wait = 0;
            m_pref = 0;
            m_cnt  = '{0, 0};
        end else if (!m_busy) begin
            if (er != 2'b00) begin
                w      = er[1] ? 1 : 0;
                amt    = (w == 1) ? req_amt1 : req_amt0;
                m_res  = rotr((w == 1) ? req_data1 : req_data0, amt);
                m_wait = (int'(amt) + 2) / 3;
                m_id   = (w == 1);
                m_pref = 1 - w;
                m_busy = 1'b1;
                m_cnt[w]++;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (res_ready) begin
            m_busy = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic txn(input int idx);
        vec_t v;
        int   lat;
        v = vecs[idx];
        req_valid = v.id ? 2'b10 : 2'b01;
        if (v.id) begin
            req_data1 = v.data;
            req_amt1  = v.amt;
        end else begin
            req_data0 = v.data;
            req_amt0  = v.amt;
        end
        res_ready = 1'b1;
        tick();
        chk("vec_accept", accepted, 1);
        req_valid = 2'b00;
        lat = 0;
        while (!res_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("vec_latency", lat, v.exp_lat);
        chk("vec_data", res_data, v.exp_data);
        chk("vec_id", res_id, v.id);
        tick();
        chk("vec_idle", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got[4];
        int n;
        int cyc;

        vecs[0] = '{1'b0, 4'b1001, 4'd1,  4'b1100, 1};
        vecs[1] = '{1'b1, 4'b0001, 4'd7,  4'b0010, 3};
        vecs[2] = '{1'b0, 4'b1010, 4'd0,  4'b1010, 0};
        vecs[3] = '{1'b1, 4'b0110, 4'd2,  4'b1001, 1};
        vecs[4] = '{1'b0, 4'b0011, 4'd3,  4'b0110, 1};
        vecs[5] = '{1'b1, 4'b1000, 4'd4,  4'b1000, 2};
        vecs[6] = '{1'b0, 4'b0101, 4'd5,  4'b1010, 2};
        vecs[7] = '{1'b1, 4'b1110, 4'd15, 4'b1101, 5};
        vecs[8] = '{1'b0, 4'b1011, 4'd12, 4'b1011, 4};
        vecs[9] = '{1'b1, 4'b0111, 4'd6,  4'b1101, 2};

        rst_n = 1'b0;
        req_valid = 2'b00;
        req_data0 = 4'h0;
        req_data1 = 4'h0;
        req_amt0  = 4'h0;
        req_amt1  = 4'h0;
        res_ready = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_res_data", res_data, 0);
        chk("reset_res_id", res_id, 0);
        chk("reset_req_ready", req_ready, 0);

        for (int i = 0; i < 10; i++) begin
            txn(i);
        end

        // amt 0 result held while the consumer stalls; both requesters held off.
        req_valid = 2'b01;
        req_data0 = 4'b1010;
        req_amt0  = 4'd0;
        res_ready = 1'b0;
        tick();
        chk("stall_accept", accepted, 1);
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            chk("stall_data", res_data, 4'b1010);
            chk("stall_ready", req_ready, 2'b00);
            chk("stall_valid", res_valid, 1);
            tick();
        end
        res_ready = 1'b1;
        tick();
        chk("stall_idle", busy, 0);
        req_valid = 2'b00;
        tick();

        // Fresh reset, then both requesters contend continuously.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_valid = 2'b11;
        req_data0 = 4'h3;
        req_amt0  = 4'd1;
        req_data1 = 4'hC;
        req_amt1  = 4'd1;
        res_ready = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 60) begin
            if (res_valid) begin
                got[n] = int'(res_id);
                n++;
            end
            if (n == 4) break;
            tick();
            cyc++;
        end
        chk("rr_count", n, 4);
        chk("rr_grant0", got[0], 0);
        chk("rr_grant1", got[1], 1);
        chk("rr_grant2", got[2], 0);
        chk("rr_grant3", got[3], 1);
`ifdef ROT_ARBITER_STATS_EN
        chk("rr_cnt0", grant_cnt0, 2);
        chk("rr_cnt1", grant_cnt1, 2);
`endif
        tick();
        req_valid = 2'b00;
        tick();

        // Reset in the middle of a long rotate discards it.
        req_valid = 2'b01;
        req_data0 = 4'h5;
        req_amt0  = 4'd12;
        tick();
        chk("abort_accept", accepted, 1);
        req_valid = 2'b00;
        tick();
        tick();
        chk("abort_in_rot", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_data", res_data, 0);
        chk("abort_res_id", res_id, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_result", res_valid, 0);
        end

        for (int i = 0; i < 3000; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_data0 = 4'($urandom_range(0, 15));
            req_data1 = 4'($urandom_range(0, 15));
            req_amt0  = 4'($urandom_range(0, 15));
            req_amt1  = 4'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 9) < 7);
            rst_n     = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rot_arbiter.md
ROT_ARBITER -- requirements
Module: rot_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of per-requester grant counters.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  2  request valid, bit i for requester i.
REQ-005 SHALL have port req_ready  output  2  request accepted, bit i for requester i.
REQ-006 SHALL have ports req_data0, req_data1  input  4 each  operand per requester.
REQ-007 SHALL have ports req_amt0, req_amt1  input  4 each  right-rotate amount 0..15 per requester.
REQ-008 SHALL have port res_valid  output  1  result valid.
REQ-009 SHALL have port res_ready  input  1  result consumer ready.
REQ-010 SHALL have port res_data  output  4  rotated result.
REQ-011 SHALL have port res_id  output  1  requester index that owns res_data.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ROT, DONE.
REQ-014 IDLE: req_ready is one-hot on the granted requester when any req_valid is high, else 2'b00; it is combinational from req_valid and the round-robin pointer.
REQ-015 Arbitration: single valid requester wins; if both are valid, the requester not granted last wins; pointer resets to favour requester 0.
REQ-016 Handshake (req_valid[i] & req_ready[i]) in IDLE SHALL capture data, amount and id, update the pointer, and move to ROT if amount>0, else to DONE.
REQ-017 ROT: each cycle SHALL apply step=min(rem,3) through the rotator, rem-=step; the FSM moves to DONE on the edge where rem reaches 0.
REQ-018 Latency from accept edge to res_valid: ceil(amt/3) cycles; amt=0 gives res_valid on the cycle after accept.
REQ-019 DONE: res_valid=1 and res_data/res_id are held stable until res_ready=1, then the FSM returns to IDLE; back-to-back acceptance is possible on the next cycle.
REQ-020 req_ready SHALL be 2'b00 in ROT and DONE; requests are held off, never dropped.
REQ-021 Result SHALL equal operand rotated right by (amt mod 4); bit 0 wraps into bit 3.

Reset
REQ-022 With rst_n=0 at a clock edge: state=IDLE, res_valid=0, res_data=0, res_id=0, busy=0, rem=0, pointer favours requester 0, counters=0.
REQ-023 Reset mid-ROT or mid-DONE SHALL discard the operation with no result emitted.

Configuration
REQ-024 Macro ROT_ARBITER_STATS_EN defined: outputs grant_cnt0 and grant_cnt1 (CNT_W each) count accepts per requester, wrapping modulo 2^CNT_W.
REQ-025 Macro undefined: those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-026 Package rot_pkg SHALL hold the FSM state enum, DATA_W=4, AMT_W=4, and STEP_MAX=3.
REQ-027 Datapath SHALL be one instance of the existing 4-bit rotator bshifter4b, whose select is driven by the step; no other sub-module.

Verification
REQ-028 req0 data 4'b1001 amt 1 -> res_data 4'b1100, res_id 0, res_valid one cycle after accept.
REQ-029 req1 data 4'b0001 amt 7 -> three ROT cycles (steps 3,3,1), res_data 4'b0010, res_id 1.
REQ-030 Both requesters valid continuously, res_ready=1 -> grants alternate 0,1,0,1; with STATS_EN, both counters equal 2 after four results.
REQ-031 amt 0 data 4'b1010, res_ready held 0 for 5 cycles -> res_data 4'b1010 stable, req_ready 2'b00 throughout, then IDLE one cycle after res_ready=1.
REQ-032 rst_n=0 during ROT of amt 12 -> next cycle IDLE, res_valid 0, busy 0, no result emitted afterwards.
